fll_cfg_ctrl: RTL and testbench

// Configuration controller for NB_FLL clock generators. It sits between a peripheral register

---
 rtl/fll_cfg_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_fll_cfg_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fll_cfg_ctrl.sv
// Register-port to multi-FLL configuration bridge: four-phase req/ack per channel, synchronised
// ack/lock inputs and lock-loss pulses. Optional wait-state timeout under FLL_CFG_TIMEOUT_EN.

module fll_cfg_sync_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ack_async,
    input  logic lock_async,
    output logic ack_s,
    output logic lock_s,
    output logic lock_lost
);
    logic [SYNC_STAGES-1:0] ack_ff;
    logic [SYNC_STAGES-1:0] lock_ff;
    logic                   lock_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_ff    <= '0;
            lock_ff   <= '0;
            lock_d    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            ack_ff    <= {ack_ff[SYNC_STAGES-2:0], ack_async};
            lock_ff   <= {lock_ff[SYNC_STAGES-2:0], lock_async};
            lock_d    <= lock_ff[SYNC_STAGES-1];
            lock_lost <= lock_d & ~lock_ff[SYNC_STAGES-1];
        end
    end

    assign ack_s  = ack_ff[SYNC_STAGES-1];
    assign lock_s = lock_ff[SYNC_STAGES-1];
endmodule

module fll_cfg_ctrl #(
    parameter int NB_FLL         = 2,
    parameter int SEL_WIDTH      = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_i,
    input  logic                                 we_i,
    input  logic [SEL_WIDTH-1:0]                 fll_sel_i,
    input  logic [ADDR_WIDTH-1:0]                addr_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    output logic                                 ready_o,
    output logic                                 rvalid_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 err_o,
    output logic [NB_FLL-1:0]                    fll_req_o,
    output logic [NB_FLL-1:0]                    fll_wrn_o,
    output logic [NB_FLL-1:0][ADDR_WIDTH-1:0]    fll_add_o,
    output logic [NB_FLL-1:0][DATA_WIDTH-1:0]    fll_wdata_o,
    input  logic [NB_FLL-1:0]                    fll_ack_i,
    input  logic [NB_FLL-1:0][DATA_WIDTH-1:0]    fll_rdata_i,
    input  logic [NB_FLL-1:0]                    fll_lock_i,
    output logic [NB_FLL-1:0]                    lock_o,
    output logic [NB_FLL-1:0]                    lock_lost_o
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT_LOW, S_REQ, S_REL, S_RESP} state_t;

    state_t                  state;
    logic                    we_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic [NB_FLL-1:0]       ack_s;
    logic [NB_FLL-1:0]       sel_oh;
    logic [NB_FLL-1:0]       sel_in_oh;
    logic                    ack_sel;
    logic [DATA_WIDTH-1:0]   rdata_sel;
    logic                    sel_bad;
    logic                    adv;
    logic                    tmo_hit;

    for (genvar g = 0; g < NB_FLL; g++) begin : g_lane
        fll_cfg_sync_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .ack_async  (fll_ack_i[g]),
            .lock_async (fll_lock_i[g]),
            .ack_s      (ack_s[g]),
            .lock_s     (lock_o[g]),
            .lock_lost  (lock_lost_o[g])
        );
    end

    assign ready_o = (state == S_IDLE);
    assign sel_bad = ({1'b0, fll_sel_i} >= (SEL_WIDTH+1)'(NB_FLL));

    always_comb begin
        sel_oh    = '0;
        sel_in_oh = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NB_FLL; i++) begin
            sel_oh[i]    = (sel_q == SEL_WIDTH'(i));
            sel_in_oh[i] = (fll_sel_i == SEL_WIDTH'(i));
            if (sel_q == SEL_WIDTH'(i)) begin
                ack_sel   = ack_s[i];
                rdata_sel = fll_rdata_i[i];
            end
        end
    end

    // Condition that moves a wait state forward; also restarts the timeout window.
    always_comb begin
        case (state)
            S_WAIT_LOW, S_REL: adv = ~ack_sel;
            S_REQ:             adv = ack_sel;
            default:           adv = 1'b0;
        endcase
    end

`ifdef FLL_CFG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state == S_IDLE || state == S_RESP || adv)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Never fires: wait states block until the FLL answers.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            sel_q       <= '0;
            fll_req_o   <= '0;
            fll_wrn_o   <= '1;
            fll_add_o   <= '0;
            fll_wdata_o <= '0;
            rvalid_o    <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
        end else begin
            rvalid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        sel_q   <= fll_sel_i;
                        err_o   <= 1'b0;
                        rdata_o <= '0;
                        if (sel_bad) begin
                            err_o    <= 1'b1;
                            rvalid_o <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            for (int i = 0; i < NB_FLL; i++) begin
                                if (sel_in_oh[i]) begin
                                    fll_wrn_o[i]   <= ~we_i;
                                    fll_add_o[i]   <= addr_i;
                                    fll_wdata_o[i] <= wdata_i;
                                end
                            end
                            state <= S_WAIT_LOW;
                        end
                    end
                end
                S_WAIT_LOW: begin
                    if (adv) begin
                        fll_req_o <= sel_oh;
                        state     <= S_REQ;
                    end else if (tmo_hit) begin
                        err_o    <= 1'b1;
                        rdata_o  <= '0;
                        rvalid_o <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_REQ: begin
                    if (adv) begin
                        if (!we_q) rdata_o <= rdata_sel;
                        fll_req_o <= '0;
                        state     <= S_REL;
                    end else if (tmo_hit) begin
                        fll_req_o <= '0;
                        err_o     <= 1'b1;
                        rdata_o   <= '0;
                        rvalid_o  <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_REL: begin
                    if (adv) begin
                        rvalid_o <= 1'b1;
                        state    <= S_RESP;
                    end else if (tmo_hit) begin
                        err_o    <= 1'b1;
                        rdata_o  <= '0;
                        rvalid_o <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    fll_req_o   <= '0;
                    fll_wrn_o   <= '1;
                    fll_add_o   <= '0;
                    fll_wdata_o <= '0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Randomised bench for fll_cfg_ctrl: behavioural FLL register models plus a host-side reference
// memory; timeout expectations follow FLL_CFG_TIMEOUT_EN.

module tb_fll_cfg_ctrl;
    localparam int NB = 2, SW = 3, DW = 32, AW = 2, SS = 2, TO = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_i = 1'b0, we_i = 1'b0;
    logic [SW-1:0] fll_sel_i = '0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic ready_o, rvalid_o, err_o;
    logic [DW-1:0] rdata_o;
    logic [NB-1:0] fll_req_o, fll_wrn_o;
    logic [NB-1:0][AW-1:0] fll_add_o;
    logic [NB-1:0][DW-1:0] fll_wdata_o;
    logic [NB-1:0] fll_ack_i = '0;
    logic [NB-1:0][DW-1:0] fll_rdata_i;
    logic [NB-1:0] fll_lock_i = '0;
    logic [NB-1:0] lock_o, lock_lost_o;

    int vectors = 0, errors = 0;
    int ack_dly = 3, rel_dly = 2;
    bit mute [NB];
    int mcnt [NB];
    logic [DW-1:0] fmem [NB][4];
    logic [DW-1:0] ref_mem [NB][4];
    bit mem_init = 1'b0;

    fll_cfg_ctrl #(.NB_FLL(NB), .SEL_WIDTH(SW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                   .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .fll_sel_i(fll_sel_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o),
        .fll_add_o(fll_add_o), .fll_wdata_o(fll_wdata_o), .fll_ack_i(fll_ack_i),
        .fll_rdata_i(fll_rdata_i), .fll_lock_i(fll_lock_i), .lock_o(lock_o),
        .lock_lost_o(lock_lost_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int i, int a);
        return 32'hC0DE_0000 + DW'(i * 256) + DW'(a);
    endfunction

    // FLL register model: ack ack_dly cycles after req, drop rel_dly cycles after req falls.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < NB; i++)
                for (int a = 0; a < 4; a++) fmem[i][a] <= init_val(i, a);
            mem_init <= 1'b1;
        end
        for (int i = 0; i < NB; i++) begin
            if (fll_req_o[i] && !fll_ack_i[i] && !mute[i]) begin
                if (mcnt[i] >= ack_dly) begin
                    fll_ack_i[i] <= 1'b1;
                    mcnt[i] <= 0;
                    if (!fll_wrn_o[i]) fmem[i][fll_add_o[i]] <= fll_wdata_o[i];
                end else mcnt[i] <= mcnt[i] + 1;
            end else if (!fll_req_o[i] && fll_ack_i[i]) begin
                if (mcnt[i] >= rel_dly) begin
                    fll_ack_i[i] <= 1'b0;
                    mcnt[i] <= 0;
                end else mcnt[i] <= mcnt[i] + 1;
            end else mcnt[i] <= 0;
        end
    end

    always_comb begin
        for (int i = 0; i < NB; i++)
            fll_rdata_i[i] = fll_ack_i[i] ? fmem[i][fll_add_o[i]] : 32'hBAD0_0000;
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready_o); end
        vectors++; if (fll_req_o !== '0) begin errors++; $display("FAIL rst_req: got %b want 0", fll_req_o); end
        vectors++; if (fll_wrn_o !== '1) begin errors++; $display("FAIL rst_wrn: got %b want 11", fll_wrn_o); end
        vectors++; if (fll_add_o !== '0) begin errors++; $display("FAIL rst_add: got %h want 0", fll_add_o); end
        vectors++; if (fll_wdata_o !== '0) begin errors++; $display("FAIL rst_wdata: got %h want 0", fll_wdata_o); end
        vectors++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rvalid_o); end
        vectors++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
        vectors++; if (rdata_o !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
        vectors++; if (lock_o !== '0) begin errors++; $display("FAIL rst_lock: got %b want 0", lock_o); end
        vectors++; if (lock_lost_o !== '0) begin errors++; $display("FAIL rst_lost: got %b want 0", lock_lost_o); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One host access; busy cycles see random ignored requests on the host port.
    task automatic access(input logic w, input logic [SW-1:0] s, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit exp_tmo);
        int si, rv_cnt, tail, viol, rise_bad;
        int rises [NB];
        bit bad_sel, exp_err;
        logic got_err;
        logic [DW-1:0] exp_rd, got_rd;
        logic [NB-1:0] prev;
        si = int'(s);
        bad_sel = (si >= NB);
        exp_err = bad_sel || exp_tmo;
        rv_cnt = 0; tail = 0; viol = 0; rise_bad = 0;
        got_err = 1'b0; got_rd = '0; prev = '0; exp_rd = '0;
        for (int i = 0; i < NB; i++) rises[i] = 0;
        if (!exp_err && !w) exp_rd = ref_mem[si][a];
        if (!exp_err && w) ref_mem[si][a] = d;

        vectors++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b want 1", ready_o); end
        req_i = 1'b1; we_i = w; fll_sel_i = s; addr_i = a; wdata_i = d;
        @(negedge clk);
        for (int c = 0; c < 400 && tail < 3; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (fll_req_o[i] && !prev[i]) rises[i]++;
                if (i == si && rv_cnt == 0) begin
                    if (fll_wrn_o[i] !== ~w || fll_add_o[i] !== a || (w && (fll_wdata_o[i] !== d))) viol++;
                end else if (fll_req_o[i] !== 1'b0 || fll_wrn_o[i] !== 1'b1 ||
                             fll_add_o[i] !== '0 || fll_wdata_o[i] !== '0) viol++;
            end
            prev = fll_req_o;
            if (rvalid_o === 1'b1) begin
                rv_cnt++; got_err = err_o; got_rd = rdata_o;
            end else if (rv_cnt > 0) tail++;
            req_i = ready_o ? 1'b0 : 1'($urandom);
            fll_sel_i = SW'($urandom); we_i = 1'($urandom); addr_i = AW'($urandom); wdata_i = $urandom;
            @(negedge clk);
        end
        for (int i = 0; i < NB; i++)
            if (rises[i] != ((i == si && !bad_sel) ? 1 : 0)) rise_bad++;

        vectors++; if (rv_cnt != 1) begin errors++; $display("FAIL rvalid_pulses sel=%0d: got %0d want 1", si, rv_cnt); end
        vectors++; if (got_err !== exp_err) begin errors++; $display("FAIL err sel=%0d: got %b want %b", si, got_err, exp_err); end
        vectors++; if (got_rd !== exp_rd) begin errors++; $display("FAIL rdata sel=%0d addr=%0d: got %h want %h", si, a, got_rd, exp_rd); end
        vectors++; if (rise_bad != 0) begin errors++; $display("FAIL req_pulses sel=%0d: got %0d bad channels want 0", si, rise_bad); end
        vectors++; if (viol != 0) begin errors++; $display("FAIL routing sel=%0d: got %0d bad cycles want 0", si, viol); end
    endtask

    task automatic test_write_read;
        ack_dly = 3; rel_dly = 2;
        access(1'b1, 3'd1, 2'd2, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 3'd0, 2'd1, 32'h1234_5678, 1'b0);
        access(1'b0, 3'd0, 2'd1, 32'h0, 1'b0);
        access(1'b0, 3'd1, 2'd2, 32'h0, 1'b0);
    endtask

    task automatic test_bad_sel;
        access(1'b0, 3'd2, 2'd0, 32'h0, 1'b0);
        access(1'b1, 3'd7, 2'd3, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_timeout;
        int seen;
        seen = 0;
        mute[0] = 1'b1;
`ifdef FLL_CFG_TIMEOUT_EN
        access(1'b0, 3'd0, 2'd1, 32'h0, 1'b1);
        mute[0] = 1'b0;
        access(1'b0, 3'd0, 2'd1, 32'h0, 1'b0);
`else
        req_i = 1'b1; we_i = 1'b0; fll_sel_i = 3'd0; addr_i = 2'd1;
        @(negedge clk);
        req_i = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (rvalid_o === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin errors++; $display("FAIL tmo_blocked_rvalid: got %0d want 0", seen); end
        vectors++; if (ready_o !== 1'b0) begin errors++; $display("FAIL tmo_blocked_ready: got %b want 0", ready_o); end
        vectors++; if (fll_req_o !== 2'b01) begin errors++; $display("FAIL tmo_blocked_req: got %b want 01", fll_req_o); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; mute[0] = 1'b0;
        repeat (2) @(negedge clk);
        access(1'b0, 3'd0, 2'd1, 32'h0, 1'b0);
`endif
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            ack_dly = $urandom_range(0, 4);
            rel_dly = $urandom_range(0, 4);
            access(1'($urandom), SW'($urandom_range(0, 3)), AW'($urandom), $urandom, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        int c, rv;
        rv = 0; c = 0;
        mute[1] = 1'b1;
        req_i = 1'b1; we_i = 1'b1; fll_sel_i = 3'd1; addr_i = 2'd3; wdata_i = $urandom;
        @(negedge clk);
        req_i = 1'b0;
        while (fll_req_o[1] !== 1'b1 && c < 20) begin
            @(negedge clk); c++;
        end
        vectors++; if (fll_req_o[1] !== 1'b1) begin errors++; $display("FAIL mid_reach_req: got %b want 1", fll_req_o[1]); end
        rst_n = 1'b0;
        #1;
        vectors++; if (fll_req_o !== '0) begin errors++; $display("FAIL mid_req_drop: got %b want 0", fll_req_o); end
        @(negedge clk);
        rst_n = 1'b1; mute[1] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rvalid_o === 1'b1) rv++;
        end
        vectors++; if (rv != 0) begin errors++; $display("FAIL mid_stray_rvalid: got %0d want 0", rv); end
        vectors++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_lock;
        logic [NB-1:0] prev, nl;
        int pc [NB];
        prev = fll_lock_i;
        for (int k = 0; k < 10; k++) begin
            nl = (k == 0) ? NB'(3) : (k == 1) ? NB'(1) : NB'($urandom);
            fll_lock_i = nl;
            for (int i = 0; i < NB; i++) pc[i] = 0;
            repeat (8) begin
                @(negedge clk);
                for (int i = 0; i < NB; i++) if (lock_lost_o[i] === 1'b1) pc[i]++;
            end
            vectors++; if (lock_o !== nl) begin errors++; $display("FAIL lock_level step=%0d: got %b want %b", k, lock_o, nl); end
            for (int i = 0; i < NB; i++) begin
                vectors++;
                if (pc[i] != ((prev[i] && !nl[i]) ? 1 : 0)) begin
                    errors++; $display("FAIL lock_lost step=%0d ch=%0d: got %0d pulses want %0d", k, i, pc[i], (prev[i] && !nl[i]) ? 1 : 0);
                end
            end
            prev = nl;
        end
    endtask

    initial begin
        for (int i = 0; i < NB; i++) begin
            mute[i] = 1'b0;
            for (int a = 0; a < 4; a++) ref_mem[i][a] = init_val(i, a);
        end
        test_reset;
        test_write_read;
        test_bad_sel;
        test_timeout;
        test_random;
        test_reset_mid;
        test_lock;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
